// File: rtl/cl_mcl_pkg.sv
// Shared types and field layout for the manycore-FIFO to AXI-Lite master bridge.
package cl_mcl_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR      = 3'd1,
    S_WR_RESP = 3'd2,
    S_RD_ADDR = 3'd3,
    S_RD_DATA = 3'd4,
    S_RESP    = 3'd5
  } state_e;

  localparam int req_data_lsb_lp   = 0;
  localparam int req_addr_lsb_lp   = 32;
  localparam int req_wstrb_lsb_lp  = 64;
  localparam int req_op_bit_lp     = 68;
  localparam int req_tag_lsb_lp    = 69;

  localparam int resp_rdata_lsb_lp = 0;
  localparam int resp_code_lsb_lp  = 32;
  localparam int resp_op_bit_lp    = 34;
  localparam int resp_tag_lsb_lp   = 35;

  localparam int default_tag_width_lp = 8;

  // Tag-independent low portion of each entry; the tag sits directly above it.
  typedef struct packed {
    logic        op;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] data;
  } req_base_s;

  typedef struct packed {
    logic        op;
    logic [1:0]  code;
    logic [31:0] rdata;
  } resp_base_s;

  typedef struct packed {
    logic [default_tag_width_lp-1:0] tag;
    req_base_s                       base;
  } req_s;

  typedef struct packed {
    logic [default_tag_width_lp-1:0] tag;
    resp_base_s                      base;
  } resp_s;

  function automatic logic [31:0] word_to_byte_addr(input logic [31:0] base,
                                                    input logic [31:0] word);
    return base + {word[29:0], 2'b00};
  endfunction

endpackage

// File: rtl/bsg_fifos_to_axil_master_if.sv
// AXI-Lite bus between the bridge (master) and the host interconnect (slave).
interface bsg_fifos_to_axil_master_if;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport master (
    output awaddr, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input  bresp, bvalid, output bready,
    output araddr, arvalid, input arready,
    input  rdata, rresp, rvalid, output rready
  );

  modport slave (
    input  awaddr, awvalid, output awready,
    input  wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input  araddr, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/bsg_fifos_to_axil_master.sv
// Turns one request FIFO entry into one AXI-Lite read or write and returns one
// response entry; a single transaction is in flight at a time.
module bsg_fifos_to_axil_master
  import cl_mcl_pkg::*;
#(
  parameter int          fifo_width_p     = 128,
  parameter logic [31:0] axil_base_addr_p = 32'h0000_0000,
  parameter int          tag_width_p      = 8
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,
  input  logic                        req_v_i,
  input  logic [fifo_width_p-1:0]     req_data_i,
  output logic                        req_ready_o,
  output logic                        resp_v_o,
  output logic [fifo_width_p-1:0]     resp_data_o,
  input  logic                        resp_ready_i,
  bsg_fifos_to_axil_master_if.master  m_axil,
  output logic [31:0]                 num_wr_o,
  output logic [31:0]                 num_rd_o,
  output logic                        err_o
);

  state_e                 state_q, state_d;
  logic                   req_ready_q, req_ready_d;
  logic                   resp_v_q, resp_v_d;
  logic                   awvalid_q, awvalid_d;
  logic                   wvalid_q, wvalid_d;
  logic                   bready_q, bready_d;
  logic                   arvalid_q, arvalid_d;
  logic                   rready_q, rready_d;
  logic [31:0]            addr_q, addr_d;
  logic [31:0]            wdata_q, wdata_d;
  logic [3:0]             wstrb_q, wstrb_d;
  logic                   op_q, op_d;
  logic [tag_width_p-1:0] tag_q, tag_d;
  logic [1:0]             code_q, code_d;
  logic [31:0]            rdata_q, rdata_d;
  logic [31:0]            num_wr_q, num_wr_d;
  logic [31:0]            num_rd_q, num_rd_d;
  logic                   err_q, err_d;

  req_base_s              req_base_s_s;
  logic [tag_width_p-1:0] req_tag_s;
  logic                   aw_fire_s, w_fire_s, aw_done_s, w_done_s;
  logic                   unused_req_bits_s;

  assign req_base_s_s      = req_data_i[req_tag_lsb_lp-1:0];
  assign req_tag_s         = req_data_i[req_tag_lsb_lp +: tag_width_p];
  assign unused_req_bits_s = ^req_data_i[fifo_width_p-1:req_tag_lsb_lp+tag_width_p];

  // A write channel is done once its valid has dropped or is handshaking now.
  assign aw_fire_s = awvalid_q & m_axil.awready;
  assign w_fire_s  = wvalid_q & m_axil.wready;
  assign aw_done_s = ~awvalid_q | aw_fire_s;
  assign w_done_s  = ~wvalid_q | w_fire_s;

  // Next-state and next-register values for the transaction sequencer.
  always_comb begin
    state_d     = state_q;
    req_ready_d = req_ready_q;
    resp_v_d    = resp_v_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    op_d        = op_q;
    tag_d       = tag_q;
    code_d      = code_q;
    rdata_d     = rdata_q;
    num_wr_d    = num_wr_q;
    num_rd_d    = num_rd_q;
    err_d       = err_q;

    case (state_q)
      S_IDLE: begin
        if (req_ready_q && req_v_i) begin
          req_ready_d = 1'b0;
          addr_d      = word_to_byte_addr(axil_base_addr_p, req_base_s_s.addr);
          wdata_d     = req_base_s_s.data;
          wstrb_d     = req_base_s_s.wstrb;
          op_d        = req_base_s_s.op;
          tag_d       = req_tag_s;
          if (req_base_s_s.op) begin
            state_d   = S_WR;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d   = S_RD_ADDR;
            arvalid_d = 1'b1;
          end
        end else begin
          req_ready_d = 1'b1;
        end
      end
      S_WR: begin
        awvalid_d = awvalid_q & ~aw_fire_s;
        wvalid_d  = wvalid_q & ~w_fire_s;
        if (aw_done_s && w_done_s) begin
          state_d  = S_WR_RESP;
          bready_d = 1'b1;
        end else begin
          state_d  = S_WR;
        end
      end
      S_WR_RESP: begin
        if (m_axil.bvalid) begin
          state_d  = S_RESP;
          bready_d = 1'b0;
          resp_v_d = 1'b1;
          code_d   = m_axil.bresp;
          rdata_d  = 32'd0;
          num_wr_d = num_wr_q + 32'd1;
          err_d    = err_q | (|m_axil.bresp);
        end else begin
          state_d  = S_WR_RESP;
        end
      end
      S_RD_ADDR: begin
        if (m_axil.arready) begin
          state_d   = S_RD_DATA;
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
        end else begin
          state_d   = S_RD_ADDR;
        end
      end
      S_RD_DATA: begin
        if (m_axil.rvalid) begin
          state_d  = S_RESP;
          rready_d = 1'b0;
          resp_v_d = 1'b1;
          code_d   = m_axil.rresp;
          rdata_d  = m_axil.rdata;
          num_rd_d = num_rd_q + 32'd1;
          err_d    = err_q | (|m_axil.rresp);
        end else begin
          state_d  = S_RD_DATA;
        end
      end
      S_RESP: begin
        if (resp_ready_i) begin
          state_d     = S_IDLE;
          resp_v_d    = 1'b0;
          req_ready_d = 1'b1;
        end else begin
          state_d     = S_RESP;
        end
      end
      default: begin
        state_d     = S_IDLE;
        req_ready_d = 1'b0;
        resp_v_d    = 1'b0;
        awvalid_d   = 1'b0;
        wvalid_d    = 1'b0;
        bready_d    = 1'b0;
        arvalid_d   = 1'b0;
        rready_d    = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset drops any in-flight transaction.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= S_IDLE;
      req_ready_q <= 1'b0;
      resp_v_q    <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      wstrb_q     <= 4'd0;
      op_q        <= 1'b0;
      tag_q       <= '0;
      code_q      <= 2'd0;
      rdata_q     <= 32'd0;
      num_wr_q    <= 32'd0;
      num_rd_q    <= 32'd0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      resp_v_q    <= resp_v_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      op_q        <= op_d;
      tag_q       <= tag_d;
      code_q      <= code_d;
      rdata_q     <= rdata_d;
      num_wr_q    <= num_wr_d;
      num_rd_q    <= num_rd_d;
      err_q       <= err_d;
    end
  end

  // Response entry is pure wiring of registered fields; unused upper bits are zero.
  always_comb begin
    resp_data_o = '0;
    resp_data_o[resp_tag_lsb_lp +: tag_width_p] = tag_q;
    resp_data_o[resp_op_bit_lp:0] = {op_q, code_q, rdata_q};
  end

  assign req_ready_o    = req_ready_q;
  assign resp_v_o       = resp_v_q;
  assign m_axil.awaddr  = addr_q;
  assign m_axil.awvalid = awvalid_q;
  assign m_axil.wdata   = wdata_q;
  assign m_axil.wstrb   = wstrb_q;
  assign m_axil.wvalid  = wvalid_q;
  assign m_axil.bready  = bready_q;
  assign m_axil.araddr  = addr_q;
  assign m_axil.arvalid = arvalid_q;
  assign m_axil.rready  = rready_q;
  assign num_wr_o       = num_wr_q;
  assign num_rd_o       = num_rd_q;
  assign err_o          = err_q;

endmodule
